decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode_if.sv | 23 ++
 rtl/decode.sv | 111 +++++++++++
 tb/tb_decode.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// Decode bus: the instruction word in, the decoded fields and control bits out.
interface decode_if;
  logic [31:0] instruction_encoding;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic [7:0]  control_unit_signal;
  logic        flush_cs;

  modport master (
    output instruction_encoding,
    input  opcode, funct3, funct7, rs1, rs2, rd, imm, alu_op, control_unit_signal, flush_cs
  );
  modport slave (
    input  instruction_encoding,
    output opcode, funct3, funct7, rs1, rs2, rd, imm, alu_op, control_unit_signal, flush_cs
  );
endinterface

// File: rtl/decode.sv
// RV32I single-cycle-latency decoder: combinational field/immediate/control
// extraction followed by one output register stage.
module decode (
  input  logic       clk,
  input  logic       rst,
  decode_if.slave    bus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  alu_f3;
  logic [4:0]  n_rs1;
  logic [31:0] n_imm;
  logic [3:0]  n_alu;
  logic [7:0]  n_cu;
  logic        n_flush;

  assign instr = bus.instruction_encoding;
  assign op    = instr[6:0];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // funct7[5] selects SUB only for register-register ops; shifts honour it in both forms
  always_comb begin
    alu_f3 = ALU_ADD;
    case (instr[14:12])
      3'b000: alu_f3 = (op == OP_RTYPE && instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_f3 = ALU_SLL;
      3'b010: alu_f3 = ALU_SLT;
      3'b011: alu_f3 = ALU_SLTU;
      3'b100: alu_f3 = ALU_XOR;
      3'b101: alu_f3 = instr[30] ? ALU_SRA : ALU_SRL;
      3'b110: alu_f3 = ALU_OR;
      3'b111: alu_f3 = ALU_AND;
      default: alu_f3 = ALU_ADD;
    endcase
  end

  // Control bits: {reg_we, alu_src, mem_to_reg, mem_read, mem_we, branch, jump, jalr}
  always_comb begin
    n_rs1   = instr[19:15];
    n_imm   = 32'd0;
    n_alu   = ALU_ADD;
    n_cu    = 8'h00;
    n_flush = 1'b0;
    case (op)
      OP_LUI:    begin n_cu = 8'hC0; n_imm = imm_u; n_rs1 = 5'd0; end
      OP_AUIPC:  begin n_cu = 8'hC0; n_imm = imm_u; end
      OP_JAL:    begin n_cu = 8'h82; n_imm = imm_j; end
      OP_JALR:   begin n_cu = 8'hC3; n_imm = imm_i; end
      OP_BRANCH: begin n_cu = 8'h04; n_imm = imm_b; n_alu = ALU_SUB; end
      OP_LOAD:   begin n_cu = 8'hF0; n_imm = imm_i; end
      OP_STORE:  begin n_cu = 8'h48; n_imm = imm_s; end
      OP_ITYPE:  begin n_cu = 8'hC0; n_imm = imm_i; n_alu = alu_f3; end
      OP_RTYPE:  begin n_cu = 8'h80; n_alu = alu_f3; end
      default:   n_flush = 1'b1;
    endcase
  end

  // Reset leaves a bubble in the stage so downstream treats it as a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.opcode              <= '0;
      bus.funct3              <= '0;
      bus.funct7              <= '0;
      bus.rs1                 <= '0;
      bus.rs2                 <= '0;
      bus.rd                  <= '0;
      bus.imm                 <= '0;
      bus.alu_op              <= '0;
      bus.control_unit_signal <= '0;
      bus.flush_cs            <= 1'b1;
    end else begin
      bus.opcode              <= op;
      bus.funct3              <= instr[14:12];
      bus.funct7              <= instr[31:25];
      bus.rs1                 <= n_rs1;
      bus.rs2                 <= instr[24:20];
      bus.rd                  <= instr[11:7];
      bus.imm                 <= n_imm;
      bus.alu_op              <= n_alu;
      bus.control_unit_signal <= n_cu;
      bus.flush_cs            <= n_flush;
    end
  end
endmodule

// File: tb/tb_decode.sv
// Directed and random checks of the decoder against a table-driven RV32I model.
module tb_decode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  decode_if bus ();
  decode u_dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [7:0]  cu;
    logic        flush;
  } exp_t;

  logic [6:0] valid_ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  logic [3:0] alu_by_f3 [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  function automatic logic [31:0] sext(input int v, input int bits);
    int s;
    s = (v << (32 - bits)) >>> (32 - bits);
    return s;
  endfunction

  function automatic exp_t model(input logic [31:0] w, input bit r);
    exp_t e;
    int   f3;
    e = '0;
    if (r) begin
      e.flush = 1'b1;
      return e;
    end
    e.opcode = w[6:0];
    e.funct3 = w[14:12];
    e.funct7 = w[31:25];
    e.rs1    = w[19:15];
    e.rs2    = w[24:20];
    e.rd     = w[11:7];
    f3       = int'(w[14:12]);
    e.flush  = 1'b0;
    case (w[6:0])
      7'h37: begin e.cu = 8'hC0; e.imm = w & 32'hFFFFF000; e.rs1 = 0; end
      7'h17: begin e.cu = 8'hC0; e.imm = w & 32'hFFFFF000; end
      7'h6F: begin
        e.cu  = 8'h82;
        e.imm = sext(int'(w[31]) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21);
      end
      7'h67: begin e.cu = 8'hC3; e.imm = sext(int'(w[31:20]), 12); end
      7'h63: begin
        e.cu = 8'h04; e.alu_op = 4'd1;
        e.imm = sext(int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13);
      end
      7'h03: begin e.cu = 8'hF0; e.imm = sext(int'(w[31:20]), 12); end
      7'h23: begin e.cu = 8'h48; e.imm = sext(int'(w[31:25]) * 32 + int'(w[11:7]), 12); end
      7'h13, 7'h33: begin
        e.cu     = (w[6:0] == 7'h13) ? 8'hC0 : 8'h80;
        e.imm    = (w[6:0] == 7'h13) ? sext(int'(w[31:20]), 12) : 32'd0;
        e.alu_op = alu_by_f3[f3];
        if (f3 == 5 && w[30]) e.alu_op = 4'd7;
        if (f3 == 0 && w[30] && w[6:0] == 7'h33) e.alu_op = 4'd1;
      end
      default: e.flush = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one word with the given reset level, then compare every output one edge later
  task automatic step(input logic [31:0] w, input bit r);
    exp_t e;
    @(negedge clk);
    bus.instruction_encoding = w;
    rst = r;
    @(posedge clk);
    #1;
    e = model(w, r);
    chk("opcode", 32'(bus.opcode), 32'(e.opcode));
    chk("funct3", 32'(bus.funct3), 32'(e.funct3));
    chk("funct7", 32'(bus.funct7), 32'(e.funct7));
    chk("rs1",    32'(bus.rs1),    32'(e.rs1));
    chk("rs2",    32'(bus.rs2),    32'(e.rs2));
    chk("rd",     32'(bus.rd),     32'(e.rd));
    chk("imm",    bus.imm,         e.imm);
    chk("alu_op", 32'(bus.alu_op), 32'(e.alu_op));
    chk("cu",     32'(bus.control_unit_signal), 32'(e.cu));
    chk("flush",  32'(bus.flush_cs), 32'(e.flush));
  endtask

  initial begin
    logic [31:0] rnd;
    logic [6:0]  op;
    bus.instruction_encoding = 32'h0;

    step(32'h00600093, 1'b1);
    chk("reset_flush", 32'(bus.flush_cs), 32'd1);
    chk("reset_cu", 32'(bus.control_unit_signal), 32'd0);

    step(32'h000600B7, 1'b0);
    chk("lui_op", 32'(bus.opcode), 32'h37);
    chk("lui_rd", 32'(bus.rd), 32'd1);
    chk("lui_rs1", 32'(bus.rs1), 32'd0);
    chk("lui_imm", bus.imm, 32'h00060000);
    chk("lui_cu", 32'(bus.control_unit_signal), 32'hC0);

    step(32'h00600093, 1'b0);
    chk("addi_imm", bus.imm, 32'd6);
    chk("addi_cu", 32'(bus.control_unit_signal), 32'hC0);

    step(32'h0020A423, 1'b0);
    chk("sw_rs1", 32'(bus.rs1), 32'd1);
    chk("sw_rs2", 32'(bus.rs2), 32'd2);
    chk("sw_imm", bus.imm, 32'd8);
    chk("sw_cu", 32'(bus.control_unit_signal), 32'h48);

    step(32'h00208463, 1'b0);
    chk("beq_imm", bus.imm, 32'd8);
    chk("beq_alu", 32'(bus.alu_op), 32'd1);
    chk("beq_cu", 32'(bus.control_unit_signal), 32'h04);

    step(32'h40208033, 1'b0);
    chk("sub_alu", 32'(bus.alu_op), 32'd1);
    chk("sub_cu", 32'(bus.control_unit_signal), 32'h80);

    step(32'hFFF00013, 1'b0);
    chk("neg_imm", bus.imm, 32'hFFFFFFFF);

    step(32'h00000000, 1'b0);
    chk("zero_flush", 32'(bus.flush_cs), 32'd1);
    chk("zero_cu", 32'(bus.control_unit_signal), 32'h00);

    // Reset asserted mid-stream while a valid instruction sits on the input
    step(32'h40D65293, 1'b1);
    chk("midrst_flush", 32'(bus.flush_cs), 32'd1);
    chk("midrst_imm", bus.imm, 32'd0);
    step(32'h40D65293, 1'b0);
    chk("srai_alu", 32'(bus.alu_op), 32'd7);

    for (int i = 0; i < 300; i++) begin
      rnd = $urandom();
      op  = (($urandom() % 5) == 0) ? 7'($urandom()) : valid_ops[$urandom_range(0, 8)];
      step({rnd[31:7], op}, ($urandom() % 40) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
